// File: rtl/action_scheduler_pkg.sv
// Shared action codes, gravity defaults and scheduler FSM encodings.
// The piece engine decodes act_op_t from this package as well.
package action_scheduler_pkg;

    typedef enum logic [3:0] {
        OP_NONE    = 4'd0,
        OP_HOLD    = 4'd1,
        OP_ROT_CW  = 4'd2,
        OP_ROT_CCW = 4'd3,
        OP_LEFT    = 4'd4,
        OP_RIGHT   = 4'd5,
        OP_DOWN    = 4'd6,
        OP_GRAVITY = 4'd7,
        OP_DROP    = 4'd8
    } act_op_t;

    localparam int unsigned GRAV_BASE_DEF = 48;
    localparam int unsigned GRAV_STEP_DEF = 5;
    localparam int unsigned GRAV_MIN_DEF  = 2;

    // Pending-flag bit i holds op code i+1; bit 0 is the highest priority.
    localparam int unsigned FLAG_GRAV = 6;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StLockout = 2'd2;

    function automatic act_op_t prio_op(input logic [7:0] pend);
        act_op_t op;
        op = OP_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) begin
                op = act_op_t'(4'(i + 1));
            end
        end
        return op;
    endfunction

    function automatic logic [7:0] op_mask(input act_op_t op);
        logic [7:0] m;
        logic [3:0] idx;
        m   = '0;
        idx = op - 4'd1;
        if (op != OP_NONE) begin
            m[idx[2:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/action_scheduler_gravity_timer.sv
// Level-dependent gravity period and frame counter; pulses grav_fire_o once per period.
module action_scheduler_gravity_timer #(
    parameter int unsigned GRAV_BASE = 48,
    parameter int unsigned GRAV_STEP = 5,
    parameter int unsigned GRAV_MIN  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       en_i,
    input  logic       reset_cnt_i,
    input  logic [3:0] level_i,
    output logic       grav_fire_o
);

    logic [5:0]  cnt_q, cnt_d;
    logic [11:0] prod_full;
    logic [7:0]  prod, base, diff, period, cnt_inc;

    always_comb begin
        prod_full = 12'(GRAV_STEP) * {8'd0, level_i};
        prod      = (|prod_full[11:8]) ? 8'hFF : prod_full[7:0];
        base      = 8'(GRAV_BASE);
        diff      = (base > prod) ? (base - prod) : 8'd0;
        period    = (diff < 8'(GRAV_MIN)) ? 8'(GRAV_MIN) : diff;
        cnt_inc   = {2'b00, cnt_q} + 8'd1;
        // >= rather than == so a mid-count level increase still fires promptly.
        grav_fire_o = tick_i && en_i && !reset_cnt_i && (cnt_inc >= period);

        cnt_d = cnt_q;
        if (reset_cnt_i) begin
            cnt_d = '0;
        end else if (tick_i && en_i) begin
            cnt_d = grav_fire_o ? 6'd0 : cnt_inc[5:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/action_scheduler.sv
// Serializes command pulses and gravity into one valid/ready action stream,
// with lockout after DROP/HOLD until the next piece spawns.
module action_scheduler import action_scheduler_pkg::*; #(
    parameter int unsigned GRAV_BASE = GRAV_BASE_DEF,
    parameter int unsigned GRAV_STEP = GRAV_STEP_DEF,
    parameter int unsigned GRAV_MIN  = GRAV_MIN_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_game_i,
    input  logic       cmd_left_i,
    input  logic       cmd_right_i,
    input  logic       cmd_down_i,
    input  logic       cmd_rotate_cw_i,
    input  logic       cmd_rotate_ccw_i,
    input  logic       cmd_drop_i,
    input  logic       cmd_hold_i,
    input  logic [3:0] level_i,
    input  logic       paused_i,
    input  logic       spawn_done_i,
    input  logic       act_ready_i,
    output logic       act_valid_o,
    output act_op_t    act_op_o,
    output logic       overrun_o
);

    logic [1:0] state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       act_valid_q, act_valid_d;
    act_op_t    act_op_q, act_op_d;
    logic       overrun_q, overrun_d;

    logic [7:0] cmd_vec;
    logic       accept, lock_accept, down_accept, run_en, grav_fire, reset_cnt;

    assign cmd_vec = {cmd_drop_i, 1'b0, cmd_down_i, cmd_right_i, cmd_left_i,
                      cmd_rotate_ccw_i, cmd_rotate_cw_i, cmd_hold_i};

    assign accept      = act_valid_q && act_ready_i;
    assign lock_accept = accept && ((act_op_q == OP_DROP) || (act_op_q == OP_HOLD));
    assign down_accept = accept && (act_op_q == OP_DOWN);
    assign run_en      = !paused_i && (state_q != StLockout);
    assign reset_cnt   = (state_q == StLockout) || lock_accept || down_accept;

    action_scheduler_gravity_timer #(
        .GRAV_BASE (GRAV_BASE),
        .GRAV_STEP (GRAV_STEP),
        .GRAV_MIN  (GRAV_MIN)
    ) u_gravity_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tick_i      (tick_game_i),
        .en_i        (run_en),
        .reset_cnt_i (reset_cnt),
        .level_i     (level_i),
        .grav_fire_o (grav_fire)
    );

    // Clears are applied before sets so a same-edge pulse wins.
    always_comb begin
        pend_d = pend_q;
        if (accept) begin
            pend_d = pend_d & ~op_mask(act_op_q);
            if (down_accept) begin
                pend_d[FLAG_GRAV] = 1'b0;
            end
        end
        if (grav_fire) begin
            pend_d[FLAG_GRAV] = 1'b1;
        end
        if (run_en) begin
            pend_d = pend_d | cmd_vec;
        end
        if (!run_en || lock_accept) begin
            pend_d = '0;
        end
        overrun_d = run_en && (|(cmd_vec & pend_q));
    end

    always_comb begin
        state_d     = state_q;
        act_valid_d = act_valid_q;
        act_op_d    = act_op_q;
        case (state_q)
            StIdle: begin
                if (!paused_i && (|pend_q)) begin
                    act_valid_d = 1'b1;
                    act_op_d    = prio_op(pend_q);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    act_valid_d = 1'b0;
                    act_op_d    = OP_NONE;
                    state_d     = lock_accept ? StLockout : StIdle;
                end
            end
            StLockout: begin
                if (spawn_done_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                act_valid_d = 1'b0;
                act_op_d    = OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            act_valid_q <= 1'b0;
            act_op_q    <= OP_NONE;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            act_valid_q <= act_valid_d;
            act_op_q    <= act_op_d;
            overrun_q   <= overrun_d;
        end
    end

    assign act_valid_o = act_valid_q;
    assign act_op_o    = act_op_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Directed bench for action_scheduler: priority, handshake, lockout, gravity and pause.
module tb_action_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_game = 1'b0;
    logic       cmd_left = 1'b0, cmd_right = 1'b0, cmd_down = 1'b0;
    logic       cmd_rotate_cw = 1'b0, cmd_rotate_ccw = 1'b0, cmd_drop = 1'b0, cmd_hold = 1'b0;
    logic [3:0] level = 4'd0;
    logic       paused = 1'b0;
    logic       spawn_done = 1'b0;
    logic       act_ready = 1'b0;
    logic       act_valid;
    logic [3:0] act_op;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int op_seen [16] = '{default: 0};
    int ovr_seen = 0;

    always #5 clk = ~clk;

    action_scheduler dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .tick_game_i      (tick_game),
        .cmd_left_i       (cmd_left),
        .cmd_right_i      (cmd_right),
        .cmd_down_i       (cmd_down),
        .cmd_rotate_cw_i  (cmd_rotate_cw),
        .cmd_rotate_ccw_i (cmd_rotate_ccw),
        .cmd_drop_i       (cmd_drop),
        .cmd_hold_i       (cmd_hold),
        .level_i          (level),
        .paused_i         (paused),
        .spawn_done_i     (spawn_done),
        .act_ready_i      (act_ready),
        .act_valid_o      (act_valid),
        .act_op_o         (act_op),
        .overrun_o        (overrun)
    );

    // Valid cycles per op and overrun cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (act_valid) op_seen[act_op] = op_seen[act_op] + 1;
            if (overrun) ovr_seen = ovr_seen + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {cmd_left, cmd_right, cmd_down, cmd_rotate_cw} = '0;
        {cmd_rotate_ccw, cmd_drop, cmd_hold, tick_game} = '0;
        {paused, spawn_done, act_ready} = '0;
        level = 4'd0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic grav_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_game = 1'b1;
            cyc(1);
            tick_game = 1'b0;
            cyc(3);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        act_ready = 1'b1;
        cyc(2);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %0b expected 0", act_valid);
        end
        checks++;
        if (act_op !== 4'd0) begin
            failures++; $display("FAIL reset_op: got %0d expected 0", act_op);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun);
        end
        rst = 1'b0;
        cyc(2);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL reset_idle_valid: got %0b expected 0", act_valid);
        end
    endtask

    task automatic test_single_left();
        int b4, bo;
        do_reset();
        act_ready = 1'b1;
        b4 = op_seen[4];
        bo = ovr_seen;
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL left_lat1: got valid %0b expected 0", act_valid);
        end
        cyc(1);
        checks++;
        if ({act_valid, act_op} !== 5'h14) begin
            failures++;
            $display("FAIL left_issue: got valid %0b op %0d expected 1/4", act_valid, act_op);
        end
        cyc(1);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL left_one_cycle: got valid %0b expected 0", act_valid);
        end
        cyc(4);
        checks++;
        if (op_seen[4] - b4 !== 1) begin
            failures++; $display("FAIL left_count: got %0d expected 1", op_seen[4] - b4);
        end
        checks++;
        if (ovr_seen - bo !== 0) begin
            failures++; $display("FAIL left_overrun: got %0d expected 0", ovr_seen - bo);
        end
    endtask

    task automatic test_priority_lockout();
        int b5, bo;
        logic [4:0] exp_seq [7];
        exp_seq = '{5'h12, 5'h00, 5'h14, 5'h00, 5'h18, 5'h00, 5'h00};
        do_reset();
        act_ready = 1'b1;
        {cmd_drop, cmd_left, cmd_rotate_cw} = 3'b111;
        cyc(1);
        {cmd_drop, cmd_left, cmd_rotate_cw} = 3'b000;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            checks++;
            if ({act_valid, act_op} !== exp_seq[i]) begin
                failures++;
                $display("FAIL prio_seq[%0d]: got valid %0b op %0d expected %0h",
                         i, act_valid, act_op, exp_seq[i]);
            end
        end
        b5 = op_seen[5];
        bo = ovr_seen;
        cmd_right = 1'b1;
        cyc(1);
        cmd_right = 1'b0;
        cyc(4);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL lockout_valid: got %0b expected 0", act_valid);
        end
        spawn_done = 1'b1;
        cyc(1);
        spawn_done = 1'b0;
        cyc(5);
        checks++;
        if ((op_seen[5] - b5 !== 0) || (ovr_seen - bo !== 0)) begin
            failures++;
            $display("FAIL lockout_right: got rights %0d overruns %0d expected 0/0",
                     op_seen[5] - b5, ovr_seen - bo);
        end
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        cyc(1);
        checks++;
        if ({act_valid, act_op} !== 5'h14) begin
            failures++;
            $display("FAIL post_spawn_left: got valid %0b op %0d expected 1/4", act_valid, act_op);
        end
        cyc(2);
    endtask

    task automatic test_stall_overrun();
        int bo, b4, bad;
        do_reset();
        bo = ovr_seen;
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        cyc(1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if ({act_valid, act_op} !== 5'h14) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL stall_stable: got %0d bad cycles expected 0", bad);
        end
        // Second pulse lands on the accepting edge: coalesced, flagged, and re-issued.
        act_ready = 1'b1;
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        checks++;
        if ({act_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL stall_accept: got valid %0b overrun %0b expected 0/1", act_valid, overrun);
        end
        b4 = op_seen[4];
        cyc(1);
        checks++;
        if ({act_valid, act_op, overrun} !== 6'b1_0100_0) begin
            failures++;
            $display("FAIL stall_reissue: got valid %0b op %0d ovr %0b expected 1/4/0",
                     act_valid, act_op, overrun);
        end
        cyc(6);
        checks++;
        if ((op_seen[4] - b4 !== 1) || (ovr_seen - bo !== 1)) begin
            failures++;
            $display("FAIL stall_counts: got lefts %0d overruns %0d expected 1/1",
                     op_seen[4] - b4, ovr_seen - bo);
        end
    endtask

    task automatic test_gravity();
        int b7;
        int lv [3];
        int n1 [3];
        int n2 [3];
        int e2 [3];
        lv = '{0, 9, 15};
        n1 = '{47, 2, 1};
        n2 = '{1, 4, 5};
        e2 = '{1, 2, 3};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            act_ready = 1'b1;
            level = 4'(lv[k]);
            b7 = op_seen[7];
            grav_ticks(n1[k]);
            checks++;
            if (op_seen[7] - b7 !== 0) begin
                failures++;
                $display("FAIL grav_l%0d_before: got %0d expected 0", lv[k], op_seen[7] - b7);
            end
            grav_ticks(n2[k]);
            checks++;
            if (op_seen[7] - b7 !== e2[k]) begin
                failures++;
                $display("FAIL grav_l%0d_after: got %0d expected %0d",
                         lv[k], op_seen[7] - b7, e2[k]);
            end
        end
    endtask

    task automatic test_down_resets_gravity();
        int b6, b7;
        do_reset();
        act_ready = 1'b1;
        grav_ticks(40);
        b6 = op_seen[6];
        b7 = op_seen[7];
        cmd_down = 1'b1;
        cyc(1);
        cmd_down = 1'b0;
        cyc(3);
        checks++;
        if (op_seen[6] - b6 !== 1) begin
            failures++; $display("FAIL down_issued: got %0d expected 1", op_seen[6] - b6);
        end
        grav_ticks(47);
        checks++;
        if (op_seen[7] - b7 !== 0) begin
            failures++; $display("FAIL down_grav_47: got %0d expected 0", op_seen[7] - b7);
        end
        grav_ticks(1);
        checks++;
        if (op_seen[7] - b7 !== 1) begin
            failures++; $display("FAIL down_grav_48: got %0d expected 1", op_seen[7] - b7);
        end
    endtask

    task automatic test_pause();
        int b4, b5;
        do_reset();
        act_ready = 1'b1;
        b4 = op_seen[4];
        b5 = op_seen[5];
        cmd_right = 1'b1;
        cyc(1);
        cmd_right = 1'b0;
        paused = 1'b1;
        cyc(5);
        checks++;
        if (act_valid !== 1'b0) begin
            failures++; $display("FAIL pause_no_issue: got %0b expected 0", act_valid);
        end
        paused = 1'b0;
        cyc(6);
        paused = 1'b1;
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        cyc(2);
        paused = 1'b0;
        cyc(5);
        checks++;
        if ((op_seen[5] - b5 !== 0) || (op_seen[4] - b4 !== 0)) begin
            failures++;
            $display("FAIL pause_flush: got rights %0d lefts %0d expected 0/0",
                     op_seen[5] - b5, op_seen[4] - b4);
        end
        act_ready = 1'b0;
        cmd_rotate_ccw = 1'b1;
        cyc(1);
        cmd_rotate_ccw = 1'b0;
        cyc(1);
        paused = 1'b1;
        cyc(2);
        checks++;
        if ({act_valid, act_op} !== 5'h13) begin
            failures++;
            $display("FAIL pause_hold_issue: got valid %0b op %0d expected 1/3", act_valid, act_op);
        end
        act_ready = 1'b1;
        cyc(1);
        checks++;
        if ({act_valid, act_op} !== 5'h00) begin
            failures++;
            $display("FAIL pause_complete: got valid %0b op %0d expected 0/0", act_valid, act_op);
        end
        paused = 1'b0;
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        cmd_left = 1'b1;
        cyc(1);
        cmd_left = 1'b0;
        cyc(1);
        checks++;
        if ({act_valid, act_op} !== 5'h14) begin
            failures++;
            $display("FAIL rstmid_pre: got valid %0b op %0d expected 1/4", act_valid, act_op);
        end
        rst = 1'b1;
        cyc(1);
        checks++;
        if ({act_valid, act_op} !== 5'h00) begin
            failures++;
            $display("FAIL rstmid_post: got valid %0b op %0d expected 0/0", act_valid, act_op);
        end
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_single_left();
        test_priority_lockout();
        test_stall_overrun();
        test_gravity();
        test_down_resets_gravity();
        test_pause();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/action_scheduler.md
# action_scheduler

Serializes the one-shot/DAS command pulses from `input_manager` and the level-dependent gravity timer into a single stream of piece actions for the piece engine. Uses a valid/ready handshake and issues at most one action per handshake. Sequences piece-lock/spawn lockout after DROP and HOLD, and freezes on pause. Sits between `input_manager` and the piece movement/collision engine.

## Interface
- `GRAV_BASE`, 48: gravity period in frames at level 0.
- `GRAV_STEP`, 5: frames removed per level.
- `GRAV_MIN`, 2: minimum gravity period in frames.
- `clk` in 1: system clock; the block uses one clock.
- `rst` in 1: synchronous, active-high reset.
- `tick_game` in 1: 60 Hz frame strobe, one `clk` cycle wide.
- `cmd_left`, `cmd_right`, `cmd_down`, `cmd_rotate_cw`, `cmd_rotate_ccw`, `cmd_drop`, `cmd_hold` in 1 each: command pulses from `input_manager`.
- `level` in 4: current level, 0–15.
- `paused` in 1: level signal, game paused.
- `spawn_done` in 1: pulse from the game FSM when the new piece is active.
- `act_ready` in 1: piece engine accepts the action.
- `act_valid` out 1: action offered.
- `act_op` out 4: `act_op_t` code (see Operation).
- `overrun` out 1: one-cycle pulse when a command arrives while its pending flag is already set.

## Operation
- Op codes:
  - OP_NONE=0, OP_HOLD=1, OP_ROT_CW=2, OP_ROT_CCW=3, OP_LEFT=4, OP_RIGHT=5, OP_DOWN=6, OP_GRAVITY=7, OP_DROP=8.
- Pending flags:
  - One flag per command plus one for gravity.
  - A `cmd_*` pulse sets its flag.
  - The flag clears when that op is accepted (`act_valid && act_ready`).
  - If set and clear happen at the same edge, set wins.
  - A pulse while the flag is already set is coalesced and raises `overrun` on the next cycle.
- Issue priority, highest first: HOLD, ROT_CW, ROT_CCW, LEFT, RIGHT, DOWN, GRAVITY, DROP.
- FSM states:
  - IDLE: when not paused and any flag is set, latch the highest-priority op into `act_op`, assert `act_valid`, go to ISSUE.
  - ISSUE: hold `act_valid` and `act_op` stable until accepted. On acceptance, drop `act_valid` and set `act_op`=OP_NONE.
    - Accepted DROP or HOLD: go to LOCKOUT.
    - Any other op: go to IDLE.
  - LOCKOUT: all pending flags cleared; `cmd_*` ignored (no set, no `overrun`); gravity counter held at 0. Leave to IDLE on `spawn_done`. `spawn_done` in other states is ignored.
- Gravity:
  - Period P = `GRAV_BASE` − `GRAV_STEP`·`level`, floored at `GRAV_MIN`. Use saturating arithmetic on the 8-bit product; no underflow.
  - Counter (6 bits) increments on `tick_game` in IDLE/ISSUE when not paused.
  - On a tick with counter ≥ P−1, set the gravity flag and reset the counter to 0. The ≥ covers a `level` increase mid-count.
  - Acceptance of OP_DOWN resets the counter and clears the gravity flag.
- Pause:
  - While `paused`, no new issue, pending flags cleared, commands ignored, counter frozen.
  - An action already in ISSUE completes its handshake normally.
- Reset values:
  - `act_valid`=0, `act_op`=OP_NONE, `overrun`=0.
  - State IDLE, all flags 0, counter 0.
  - Reset mid-handshake drops `act_valid` after the reset edge regardless of `act_ready`.

## Timing
- A pulse sampled at edge E sets its flag at E. `act_valid` rises after edge E+1. Latency from pulse to valid is 2 cycles.
- Acceptance at edge A: valid low after A. The next valid rises at the earliest after A+1, so there is exactly one idle cycle between back-to-back actions.
- `overrun` is registered: high for the one cycle after the offending edge.
- A gravity flag set at tick edge T produces valid after T+1, unless a higher-priority flag is pending.
- `act_op` never changes while `act_valid`=1 and `act_ready`=0.

## Structure
- `act_op_t` enum and the `GRAV_*` defaults go in the shared `GLOBAL.sv` package; the piece engine decodes the same type.
- Sub-module `gravity_timer`: level-to-period computation, frame counter, and a `reset_cnt` input. It emits `grav_fire` to the scheduler FSM.
- FSM, pending flags and priority encoder live in `action_scheduler`.

## Test plan
- Reset, pulse `cmd_left`, `act_ready`=1 → `act_valid`=1 with OP_LEFT 2 cycles after the pulse, for exactly 1 cycle; `overrun` stays 0.
- Same-cycle `cmd_drop`, `cmd_left`, `cmd_rotate_cw`, `act_ready`=1 → OP_ROT_CW, OP_LEFT, OP_DROP, each separated by 1 idle cycle. Then `cmd_right` is ignored until `spawn_done`; after it, no RIGHT is issued.
- OP_LEFT valid with `act_ready`=0 for 5 cycles, second `cmd_left` during the stall → `act_op` stable at 4, `overrun` pulses once, and after acceptance exactly one more OP_LEFT is issued.
- `level`=0: 48 `tick_game` → exactly one OP_GRAVITY. `level`=9 → period 3. `level`=15 → period 2.
- OP_DOWN accepted when the counter is at 40 with `level`=0 → the next OP_GRAVITY comes 48 ticks after acceptance, not 8.
- `paused`=1 with RIGHT pending → no issue, the flag is cleared, and nothing is issued after unpause. `rst` during ISSUE with `act_ready`=0 → `act_valid`=0 and `act_op`=0 the next cycle.
